// File: rtl/pd_miner_pkg.sv
// Shared constants and state types for the block-header buffer.
// Field offsets are byte positions inside the 80-byte block header.
package pd_miner_pkg;

    localparam int VERSION   = 0;
    localparam int PREV_HASH = 4;
    localparam int MERKLE    = 36;
    localparam int TIME      = 68;
    localparam int BITS      = 72;
    localparam int NONCE     = 76;
    localparam int HDR_BYTES = 80;

    typedef enum logic {
        FILLING = 1'b0,
        FULL    = 1'b1
    } fill_state_t;

    typedef enum logic {
        EMPTY   = 1'b0,
        PRESENT = 1'b1
    } read_state_t;

endpackage

// File: rtl/pd_header_buffer_if.sv
// Byte-write port and header presentation port of pd_header_buffer, plus FSM debug taps.
// The header is held while o_hdr_valid=1 until an edge samples i_hdr_ready=1 (that edge is the release).
interface pd_header_buffer_if
    import pd_miner_pkg::*;
#(
    parameter int NUM_BYTES    = HDR_BYTES,
    parameter int CHUNK1_BYTES = 64,
    parameter int DIFF_OFFSET  = BITS,
    parameter int DIFF_BYTES   = 4,
    parameter int ADDR_W       = $clog2(NUM_BYTES)
) ();

    logic                                     i_data_en;
    logic [7:0]                               i_data;
    logic [ADDR_W-1:0]                        i_data_sel;
    logic                                     i_hdr_ready;
    logic                                     o_wr_ready;
    logic                                     o_hdr_valid;
    logic [CHUNK1_BYTES-1:0][7:0]             o_chunk_1;
    logic [NUM_BYTES-CHUNK1_BYTES-1:0][7:0]   o_chunk_2;
    logic [DIFF_BYTES-1:0][7:0]               o_difficulty;
    logic                                     o_err_addr;
    logic                                     o_overflow;

    fill_state_t                              dbg_fill_state;
    read_state_t                              dbg_read_state;
    logic                                     dbg_ptr;
    logic [1:0]                               dbg_complete;

    modport master (
        output i_data_en, i_data, i_data_sel, i_hdr_ready,
        input  o_wr_ready, o_hdr_valid, o_chunk_1, o_chunk_2, o_difficulty,
        input  o_err_addr, o_overflow,
        input  dbg_fill_state, dbg_read_state, dbg_ptr, dbg_complete
    );

    modport slave (
        input  i_data_en, i_data, i_data_sel, i_hdr_ready,
        output o_wr_ready, o_hdr_valid, o_chunk_1, o_chunk_2, o_difficulty,
        output o_err_addr, o_overflow,
        output dbg_fill_state, dbg_read_state, dbg_ptr, dbg_complete
    );

endinterface

// File: rtl/pd_hdr_bank.sv
// One header bank: byte storage plus a per-byte written bitmap.
// fill_done flags the write that sets the last missing bitmap bit, on the same edge.
module pd_hdr_bank #(
    parameter int NUM_BYTES = 80,
    parameter int ADDR_W    = $clog2(NUM_BYTES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [7:0]                   wr_data,
    output logic [NUM_BYTES-1:0][7:0]    data,
    output logic                         fill_done,
    output logic                         complete
);

    logic [NUM_BYTES-1:0] bitmap;
    logic [NUM_BYTES-1:0] bit_sel;

    assign bit_sel   = NUM_BYTES'(1) << wr_addr;
    assign fill_done = wr_en && (&(bitmap | bit_sel));
    assign complete  = &bitmap;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bitmap <= '0;
        end else if (wr_en) begin
            bitmap <= bitmap | bit_sel;
        end
    end

    // Storage is deliberately not reset; only the bitmap decides completeness.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            data[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/pd_header_buffer.sv
// Double-buffered 80-byte header assembler: one bank fills while the other is presented.
// ptr names the read bank; the fill bank is always the other one.
module pd_header_buffer
    import pd_miner_pkg::*;
#(
    parameter int NUM_BYTES    = HDR_BYTES,
    parameter int CHUNK1_BYTES = 64,
    parameter int DIFF_OFFSET  = BITS,
    parameter int DIFF_BYTES   = 4,
    parameter int ADDR_W       = $clog2(NUM_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    pd_header_buffer_if.slave bus
);

    if (CHUNK1_BYTES >= NUM_BYTES || DIFF_OFFSET + DIFF_BYTES > NUM_BYTES) begin : g_bad_params
        $error("pd_header_buffer: CHUNK1_BYTES or difficulty field outside the header");
    end

    fill_state_t fill_q, fill_nxt;
    read_state_t read_q, read_nxt;
    logic        ptr, ptr_nxt;
    logic        wr_ready, hdr_valid;
    logic        in_range, wr_ok, release_hdr, fill_done, swap;
    logic        err_q, ovf_q;

    logic [1:0]                      bank_wr, bank_clr, bank_done, bank_complete;
    logic [NUM_BYTES-1:0][7:0]       bank_data [2];
    logic [NUM_BYTES-1:0][7:0]       rd_data;

    assign in_range    = 32'(bus.i_data_sel) < 32'(NUM_BYTES);
    assign wr_ok       = bus.i_data_en && wr_ready && in_range;
    assign release_hdr = hdr_valid && bus.i_hdr_ready;
    assign fill_done   = ptr ? bank_done[0] : bank_done[1];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_wr[b]  = wr_ok && (ptr != 1'(b));
        assign bank_clr[b] = swap && (ptr == 1'(b));

        pd_hdr_bank #(
            .NUM_BYTES (NUM_BYTES),
            .ADDR_W    (ADDR_W)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .clear     (bank_clr[b]),
            .wr_en     (bank_wr[b]),
            .wr_addr   (bus.i_data_sel),
            .wr_data   (bus.i_data),
            .data      (bank_data[b]),
            .fill_done (bank_done[b]),
            .complete  (bank_complete[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= FILLING;
            read_q <= EMPTY;
            ptr    <= 1'b0;
            err_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            fill_q <= fill_nxt;
            read_q <= read_nxt;
            ptr    <= ptr_nxt;
            err_q  <= bus.i_data_en && !in_range;
            ovf_q  <= bus.i_data_en && in_range && !wr_ready;
        end
    end

    // A swap hands the completed fill bank to the reader and recycles the old read bank.
    always_comb begin
        fill_nxt = fill_q;
        read_nxt = read_q;
        swap     = 1'b0;
        if (fill_q == FILLING && fill_done) begin
            if (read_q == EMPTY || release_hdr) begin
                swap     = 1'b1;
                read_nxt = PRESENT;
            end else begin
                fill_nxt = FULL;
            end
        end else if (release_hdr) begin
            if (fill_q == FULL) begin
                swap     = 1'b1;
                fill_nxt = FILLING;
                read_nxt = PRESENT;
            end else begin
                read_nxt = EMPTY;
            end
        end
        ptr_nxt = ptr ^ swap;
    end

    always_comb begin
        wr_ready  = (fill_q == FILLING);
        hdr_valid = (read_q == PRESENT);
        rd_data   = bank_data[ptr];
    end

    assign bus.o_wr_ready     = wr_ready;
    assign bus.o_hdr_valid    = hdr_valid;
    assign bus.o_chunk_1      = rd_data[CHUNK1_BYTES-1:0];
    assign bus.o_chunk_2      = rd_data[NUM_BYTES-1:CHUNK1_BYTES];
    assign bus.o_difficulty   = rd_data[DIFF_OFFSET+DIFF_BYTES-1:DIFF_OFFSET];
    assign bus.o_err_addr     = err_q;
    assign bus.o_overflow     = ovf_q;
    assign bus.dbg_fill_state = fill_q;
    assign bus.dbg_read_state = read_q;
    assign bus.dbg_ptr        = ptr;
    assign bus.dbg_complete   = bank_complete;

endmodule

// File: tb/tb_pd_header_buffer.sv
// Directed bench for pd_header_buffer: table of single-cycle vectors plus hand-written fill sequences.
module tb_pd_header_buffer;
    import pd_miner_pkg::*;

    localparam int NB = HDR_BYTES;
    localparam int C1 = 64;
    localparam int DO = BITS;
    localparam int DB = 4;
    localparam int AW = $clog2(NB);
    localparam int W  = NB * 8;

    typedef struct {
        logic       en;
        logic [7:0] d;
        int         sel;
        logic       rdy;
        logic       acc;
        logic       pop;
        logic       e_wr;
        logic       e_val;
        logic       e_err;
        logic       e_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;

    logic [7:0]   model [NB];
    logic [W-1:0] exp_q [$];
    vec_t         vecs [6];

    always #5 clk = ~clk;

    pd_header_buffer_if #(
        .NUM_BYTES(NB), .CHUNK1_BYTES(C1), .DIFF_OFFSET(DO), .DIFF_BYTES(DB), .ADDR_W(AW)
    ) bus ();

    pd_header_buffer #(
        .NUM_BYTES(NB), .CHUNK1_BYTES(C1), .DIFF_OFFSET(DO), .DIFF_BYTES(DB), .ADDR_W(AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_hdr(input string name);
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: no header expected in scoreboard", name);
        end else if ({bus.o_chunk_2, bus.o_chunk_1} !== exp_q[0]) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, {bus.o_chunk_2, bus.o_chunk_1}, exp_q[0]);
        end
    endtask

    task automatic push_model();
        logic [W-1:0] h;
        for (int i = 0; i < NB; i++) h[8*i +: 8] = model[i];
        exp_q.push_back(h);
    endtask

    task automatic pop_model();
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic wr(input int sel, input logic [7:0] d, input bit acc);
        bus.i_data_en  = 1'b1;
        bus.i_data_sel = AW'(sel);
        bus.i_data     = d;
        if (acc) model[sel] = d;
        tick();
        bus.i_data_en  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'h99, 80,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h98, 127, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h55, 10,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h97, 100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        bus.i_data_en   = 1'b0;
        bus.i_data      = 8'h00;
        bus.i_data_sel  = '0;
        bus.i_hdr_ready = 1'b0;
        for (int i = 0; i < NB; i++) model[i] = 8'h00;

        // reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_wr_ready", 64'(bus.o_wr_ready), 64'(1));
        chk("reset_hdr_valid", 64'(bus.o_hdr_valid), 64'(0));
        chk("reset_err_addr", 64'(bus.o_err_addr), 64'(0));
        chk("reset_overflow", 64'(bus.o_overflow), 64'(0));
        chk("reset_ptr", 64'(bus.dbg_ptr), 64'(0));
        chk("reset_complete", 64'(bus.dbg_complete), 64'(0));

        // header 0: byte value = index
        for (int i = 0; i < NB - 1; i++) wr(i, 8'(i), 1'b1);
        chk("h0_valid_before_last", 64'(bus.o_hdr_valid), 64'(0));
        wr(NB - 1, 8'(NB - 1), 1'b1);
        push_model();
        chk("h0_valid_after_last", 64'(bus.o_hdr_valid), 64'(1));
        chk("h0_wr_ready", 64'(bus.o_wr_ready), 64'(1));
        chk("h0_chunk1_0", 64'(bus.o_chunk_1[0]), 64'(8'h00));
        chk("h0_chunk2_15", 64'(bus.o_chunk_2[15]), 64'(8'h4F));
        chk("h0_difficulty", 64'(bus.o_difficulty), 64'(32'h4B4A4948));
        chk_hdr("h0_data");

        bus.i_hdr_ready = 1'b1;
        tick();
        bus.i_hdr_ready = 1'b0;
        pop_model();
        chk("h0_release_valid", 64'(bus.o_hdr_valid), 64'(0));

        // header 1: byte 5 written twice, completion needs the missing byte 79
        wr(5, 8'h11, 1'b1);
        for (int i = 0; i < NB - 1; i++) if (i != 5) wr(i, 8'(8'hA0 + i), 1'b1);
        wr(5, 8'h22, 1'b1);
        chk("h1_valid_79_distinct", 64'(bus.o_hdr_valid), 64'(0));
        wr(NB - 1, 8'hEF, 1'b1);
        push_model();
        chk("h1_valid", 64'(bus.o_hdr_valid), 64'(1));
        chk("h1_chunk1_5", 64'(bus.o_chunk_1[5]), 64'(8'h22));
        chk_hdr("h1_data");

        // header 2 fills while header 1 is held
        for (int i = 0; i < NB - 1; i++) wr(i, 8'(255 - i), 1'b1);
        chk("h2_wr_ready_before_last", 64'(bus.o_wr_ready), 64'(1));
        chk_hdr("h1_stable_mid");
        wr(NB - 1, 8'(255 - (NB - 1)), 1'b1);
        push_model();
        chk("h2_wr_ready_full", 64'(bus.o_wr_ready), 64'(0));
        chk("h2_fill_state", 64'(bus.dbg_fill_state), 64'(FULL));
        chk("h2_both_complete", 64'(bus.dbg_complete), 64'(2'b11));
        chk("h1_valid_held", 64'(bus.o_hdr_valid), 64'(1));
        chk_hdr("h1_stable_full");
        wr(3, 8'h77, 1'b0);
        chk("ovf_pulse", 64'(bus.o_overflow), 64'(1));
        chk("ovf_no_err", 64'(bus.o_err_addr), 64'(0));
        wr(90, 8'h66, 1'b0);
        chk("err_while_full", 64'(bus.o_err_addr), 64'(1));
        chk("err_while_full_no_ovf", 64'(bus.o_overflow), 64'(0));
        tick();
        chk("ovf_err_clear", 64'({bus.o_err_addr, bus.o_overflow}), 64'(0));
        chk_hdr("h1_after_drops");

        // one-cycle release swaps in header 2
        bus.i_hdr_ready = 1'b1;
        tick();
        bus.i_hdr_ready = 1'b0;
        pop_model();
        chk("h2_swap_wr_ready", 64'(bus.o_wr_ready), 64'(1));
        chk("h2_swap_valid", 64'(bus.o_hdr_valid), 64'(1));
        chk_hdr("h2_data");

        // table of single-cycle vectors: address errors, write+release on one edge
        for (int v = 0; v < 6; v++) begin
            bus.i_data_en   = vecs[v].en;
            bus.i_data      = vecs[v].d;
            bus.i_data_sel  = AW'(vecs[v].sel);
            bus.i_hdr_ready = vecs[v].rdy;
            if (vecs[v].acc) model[vecs[v].sel] = vecs[v].d;
            tick();
            bus.i_data_en   = 1'b0;
            bus.i_hdr_ready = 1'b0;
            if (vecs[v].pop) pop_model();
            chk($sformatf("vec%0d_wr_ready", v), 64'(bus.o_wr_ready), 64'(vecs[v].e_wr));
            chk($sformatf("vec%0d_hdr_valid", v), 64'(bus.o_hdr_valid), 64'(vecs[v].e_val));
            chk($sformatf("vec%0d_err_addr", v), 64'(bus.o_err_addr), 64'(vecs[v].e_err));
            chk($sformatf("vec%0d_overflow", v), 64'(bus.o_overflow), 64'(vecs[v].e_ovf));
            if (vecs[v].e_val) chk_hdr($sformatf("vec%0d_hdr", v));
        end

        // header 3: byte 10 already landed on the release edge
        for (int i = 0; i < NB; i++) begin
            if (i != 10) begin
                if (i == NB - 1) chk("h3_valid_before_last", 64'(bus.o_hdr_valid), 64'(0));
                wr(i, 8'(i * 3), 1'b1);
            end
        end
        push_model();
        chk("h3_valid", 64'(bus.o_hdr_valid), 64'(1));
        chk("h3_byte10", 64'(bus.o_chunk_1[10]), 64'(8'h55));
        chk_hdr("h3_data");

        // reset mid-fill with a header presented and a write on the reset edge
        for (int i = 0; i < 40; i++) wr(i, 8'(i + 7), 1'b1);
        rst = 1'b1;
        wr(40, 8'hEE, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        chk("rst_hdr_valid", 64'(bus.o_hdr_valid), 64'(0));
        chk("rst_wr_ready", 64'(bus.o_wr_ready), 64'(1));
        chk("rst_ptr", 64'(bus.dbg_ptr), 64'(0));
        for (int i = 40; i < NB; i++) wr(i, 8'(i ^ 8'h5A), 1'b1);
        chk("rst_partial_discarded", 64'(bus.o_hdr_valid), 64'(0));
        for (int i = 0; i < 40; i++) wr(i, 8'(i ^ 8'h5A), 1'b1);
        push_model();
        chk("rst_refill_valid", 64'(bus.o_hdr_valid), 64'(1));
        chk("rst_refill_read_state", 64'(bus.dbg_read_state), 64'(PRESENT));
        chk_hdr("rst_refill_data");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
